// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the fetch/data memory arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
    localparam int unsigned REQ_IF = 0;
    localparam int unsigned REQ_D  = 1;
endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, data is treated as last-granted after reset
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    logic last_d;
    always_comb begin
        grant[0] = req[0] & (~req[1] | last_d);
        grant[1] = req[1] & (~req[0] | ~last_d);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) last_d <= 1'b1;
        else if (|grant) last_d <= grant[1];
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-cycle RAM port between instruction fetch and load/store
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wd,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rd
);
    logic [1:0] req, grant;
    owner_e     owner;
    logic       store_q;
    assign req = {d_req & rst_n, if_req & rst_n};
    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner   <= OWN_NONE;
            store_q <= 1'b0;
        end else begin
            owner   <= grant[REQ_IF] ? OWN_IF : grant[REQ_D] ? OWN_D : OWN_NONE;
            store_q <= grant[REQ_D] & d_we;
        end
    end
    always_comb begin
        if_gnt    = grant[REQ_IF];
        d_gnt     = grant[REQ_D];
        mem_addr  = grant[REQ_D] ? d_addr : if_addr;
        mem_we    = grant[REQ_D] & d_we;
        mem_wd    = d_wdata;
        mem_be    = grant[REQ_D] ? d_be : {(DATA_W/8){grant[REQ_IF]}};
        if_rvalid = rst_n && owner == OWN_IF;
        d_rvalid  = rst_n && owner == OWN_D;
        if_rdata  = if_rvalid ? mem_rd : '0;
        d_rdata   = (d_rvalid && !store_q) ? mem_rd : '0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors against hand-computed expectations
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rd, if_rdata, d_rdata, mem_addr, mem_wd;
    logic [3:0]  d_be, mem_be;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_be(mem_be), .mem_rd(mem_rd)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] dwd, input logic [3:0] be, input logic [31:0] rd);
        @(negedge clk);
        rst_n = rn; if_req = ir; if_addr = ia; d_req = dr; d_we = dw;
        d_addr = da; d_wdata = dwd; d_be = be; mem_rd = rd;
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic ig, input logic dg, input logic iv, input logic dv);
        chk({tag, ".if_gnt"}, if_gnt, ig);
        chk({tag, ".d_gnt"}, d_gnt, dg);
        chk({tag, ".if_rvalid"}, if_rvalid, iv);
        chk({tag, ".d_rvalid"}, d_rvalid, dv);
    endtask

    initial begin
        drive(0, 1, 32'h8000_0000, 1, 1, 32'h10, 32'h1, 4'hF, 32'h99);
        chk_bus("rst0", 0, 0, 0, 0);
        chk("rst0.mem_we", mem_we, 0);
        chk("rst0.mem_be", mem_be, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h99);
        chk_bus("rst1", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 32'hA5A5_0000 + i);
            chk_bus($sformatf("idle%0d", i), 0, 0, 0, 0);
            chk($sformatf("idle%0d.mem_we", i), mem_we, 0);
            chk($sformatf("idle%0d.mem_be", i), mem_be, 0);
            chk($sformatf("idle%0d.if_rdata", i), if_rdata, 0);
            chk($sformatf("idle%0d.d_rdata", i), d_rdata, 0);
        end
        drive(1, 1, 32'h8000_0010, 1, 0, 32'h8000_0300, 0, 4'hF, 32'h0);
        chk_bus("cont1", 1, 0, 0, 0);
        chk("cont1.mem_addr", mem_addr, 32'h8000_0010);
        drive(1, 1, 32'h8000_0010, 1, 0, 32'h8000_0300, 0, 4'hF, 32'h11);
        chk_bus("cont2", 0, 1, 1, 0);
        chk("cont2.mem_addr", mem_addr, 32'h8000_0300);
        chk("cont2.if_rdata", if_rdata, 32'h11);
        drive(1, 1, 32'h8000_0014, 1, 0, 32'h8000_0300, 0, 4'hF, 32'h22);
        chk_bus("cont3", 1, 0, 0, 1);
        chk("cont3.d_rdata", d_rdata, 32'h22);
        chk("cont3.if_rdata", if_rdata, 0);
        drive(1, 1, 32'h8000_0014, 1, 0, 32'h8000_0304, 0, 4'hF, 32'h33);
        chk_bus("cont4", 0, 1, 1, 0);
        chk("cont4.if_rdata", if_rdata, 32'h33);
        chk("cont4.mem_we", mem_we, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h44);
        chk_bus("cont5", 0, 0, 0, 1);
        chk("cont5.d_rdata", d_rdata, 32'h44);
        drive(1, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 32'h0);
        chk_bus("fetch", 1, 0, 0, 0);
        chk("fetch.mem_addr", mem_addr, 32'h8000_0000);
        chk("fetch.mem_we", mem_we, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h13);
        chk_bus("fetch.rsp", 0, 0, 1, 0);
        chk("fetch.if_rdata", if_rdata, 32'h13);
        drive(1, 0, 0, 1, 1, 32'h8000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0);
        chk_bus("store", 0, 1, 0, 0);
        chk("store.mem_we", mem_we, 1);
        chk("store.mem_wd", mem_wd, 32'hDEAD_BEEF);
        chk("store.mem_addr", mem_addr, 32'h8000_0100);
        chk("store.mem_be", mem_be, 4'hF);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678);
        chk_bus("store.ack", 0, 0, 0, 1);
        chk("store.d_rdata", d_rdata, 0);
        drive(1, 0, 0, 1, 0, 32'h8000_0200, 0, 4'hF, 32'h0);
        chk_bus("ld0", 0, 1, 0, 0);
        chk("ld0.mem_addr", mem_addr, 32'h8000_0200);
        chk("ld0.mem_we", mem_we, 0);
        drive(1, 0, 0, 1, 0, 32'h8000_0204, 0, 4'hF, 32'hAAAA_0001);
        chk_bus("ld1", 0, 1, 0, 1);
        chk("ld1.mem_addr", mem_addr, 32'h8000_0204);
        chk("ld1.d_rdata", d_rdata, 32'hAAAA_0001);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'hAAAA_0002);
        chk_bus("ld2", 0, 0, 0, 1);
        chk("ld2.d_rdata", d_rdata, 32'hAAAA_0002);
        drive(1, 1, 32'h8000_0020, 0, 0, 0, 0, 0, 32'h0);
        chk_bus("mid.gnt", 1, 0, 0, 0);
        drive(0, 1, 32'h8000_0020, 1, 0, 32'h8000_0400, 0, 4'hF, 32'h77);
        chk_bus("mid.rst", 0, 0, 0, 0);
        chk("mid.rst.mem_be", mem_be, 0);
        chk("mid.rst.if_rdata", if_rdata, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h55);
        chk_bus("mid.rel", 0, 0, 0, 0);
        chk("mid.rel.if_rdata", if_rdata, 0);
        drive(1, 1, 32'h8000_0024, 1, 0, 32'h8000_0400, 0, 4'hF, 32'h0);
        chk_bus("mid.tie", 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h66);
        chk_bus("mid.rsp", 0, 0, 1, 0);
        chk("mid.rsp.if_rdata", if_rdata, 32'h66);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
